alu_mc: RTL

Multi-cycle, parametrised successor to the single-cycle RV32I ALU. It adds the RV32M multiply/divide ops, computed iteratively, on top of the base integer, branch and address ops. A valid/ready handshake sits on both input and output. It lives in the execute stage: decode presents operands and opcode fields, and writeback/branch logic consumes the result and branch flag.

---
 rtl/alu_mc_if.sv | 30 +++
 rtl/alu_mc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: execute-stage handshake bundle between decode and the alu_mc block.
//   master : decode side; drives in_valid, operands, instruction fields, flush, out_ready.
//   slave  : alu_mc side; drives in_ready, out_valid, result, branch.
//   XLEN   : operand/result width.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] y;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [6:0]      opcode;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch;

  modport master (
    output in_valid, x, y, funct7, funct3, opcode, flush, out_ready,
    input  in_ready, out_valid, result, branch
  );

  modport slave (
    input  in_valid, x, y, funct7, funct3, opcode, flush, out_ready,
    output in_ready, out_valid, result, branch
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/RV32M execute-stage ALU with valid/ready on both sides.
//   clk  : rising-edge clock.
//   rst  : asynchronous active-high reset.
//   bus  : alu_mc_if.slave -- in_valid/in_ready, x, y, funct7, funct3, opcode,
//          flush, out_valid/out_ready, registered result and branch flag.
// Base ops and divide special cases finish in one cycle; MUL*/DIV*/REM* run an
// XLEN-step shift-add / restoring-divide loop on magnitudes, with the sign
// correction folded into the last step.
module alu_mc #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_nxt_s;
  logic [SHW-1:0]    cnt_r;
  logic [XLEN-1:0]   hi_r, lo_r, opnd_r;
  logic              neg_q_r, neg_rem_r;
  logic [2:0]        func_r;
  logic [XLEN-1:0]   result_r;
  logic              branch_r;
  logic              in_ready_s, out_valid_s;

  // Opcode bits [1:0] are always 2'b11 for 32-bit encodings and carry no information.
  logic unused_opcode_s;
  assign unused_opcode_s = ^bus.opcode[1:0];

  // ---------------- decode of the presented operation ----------------
  logic [4:0]      opc_s;
  logic [SHW-1:0]  shamt_s;
  logic            is_m_s, is_div_s, div_y_zero_s, div_ovf_s, div_special_s;
  logic            iter_op_s, accept_s;

  assign opc_s         = bus.opcode[6:2];
  assign shamt_s       = bus.y[SHW-1:0];
  assign is_m_s        = (opc_s == OPC_OP) && (bus.funct7 == 7'b0000001);
  assign is_div_s      = is_m_s & bus.funct3[2];
  assign div_y_zero_s  = (bus.y == ZERO);
  assign div_ovf_s     = ~bus.funct3[0] & (bus.x == MIN_NEG) & (bus.y == ALL_ONES);
  assign div_special_s = is_div_s & (div_y_zero_s | div_ovf_s);
  assign iter_op_s     = is_m_s & ~div_special_s;
  // flush in IDLE wins over in_valid
  assign accept_s      = (state_r == IDLE) & bus.in_valid & ~bus.flush;

  // Adder/subtractor shared by add, sub, compares and branches.
  logic [XLEN-1:0] sum_s;
  logic [XLEN:0]   sub_s;
  logic            ovf_s, lt_s, ltu_s, eq_s;

  assign sum_s = bus.x + bus.y;
  assign sub_s = {1'b0, bus.x} + {1'b0, ~bus.y} + {{XLEN{1'b0}}, 1'b1};
  assign ovf_s = (bus.x[XLEN-1] ^ bus.y[XLEN-1]) & (sub_s[XLEN-1] ^ bus.x[XLEN-1]);
  assign lt_s  = sub_s[XLEN-1] ^ ovf_s;
  assign ltu_s = ~sub_s[XLEN];
  assign eq_s  = (sub_s[XLEN-1:0] == ZERO);

  // Operand signs/magnitudes for the iterative loop. MULH: both signed,
  // MULHSU: x only, MUL/MULHU unsigned; DIV/REM signed, DIVU/REMU unsigned.
  logic            sx_s, sy_s;
  logic [XLEN-1:0] mag_x_s, mag_y_s;

  assign sx_s    = bus.x[XLEN-1] & (is_div_s ? ~bus.funct3[0]
                                    : ((bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10)));
  assign sy_s    = bus.y[XLEN-1] & (is_div_s ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01));
  assign mag_x_s = sx_s ? (ZERO - bus.x) : bus.x;
  assign mag_y_s = sy_s ? (ZERO - bus.y) : bus.y;

  // Single-cycle result and branch flag (base ops and divide special cases).
  logic [XLEN-1:0] single_res_s;
  logic            single_br_s;

  always_comb begin
    single_res_s = ZERO;
    single_br_s  = 1'b0;
    case (opc_s)
      OPC_LOAD, OPC_STORE, OPC_AUIPC: single_res_s = sum_s;
      OPC_JAL, OPC_JALR: begin
        single_res_s = sum_s;
        single_br_s  = 1'b1;
      end
      OPC_LUI: single_res_s = bus.y;
      OPC_BRANCH: begin
        single_res_s = sub_s[XLEN-1:0];
        case (bus.funct3)
          3'b000:  single_br_s = eq_s;
          3'b001:  single_br_s = ~eq_s;
          3'b100:  single_br_s = lt_s;
          3'b101:  single_br_s = ~lt_s;
          3'b110:  single_br_s = ltu_s;
          3'b111:  single_br_s = ~ltu_s;
          default: single_br_s = 1'b0;
        endcase
      end
      OPC_OP_IMM, OPC_OP: begin
        if (is_m_s) begin
          // only reached for the divide special cases; REM* select on funct3[1]
          if (div_y_zero_s) begin
            single_res_s = bus.funct3[1] ? bus.x : ALL_ONES;
          end else begin
            single_res_s = bus.funct3[1] ? ZERO : bus.x;
          end
        end else begin
          case (bus.funct3)
            3'b000:  single_res_s = ((opc_s == OPC_OP) && bus.funct7[5]) ? sub_s[XLEN-1:0] : sum_s;
            3'b001:  single_res_s = bus.x << shamt_s;
            3'b010:  single_res_s = {{(XLEN-1){1'b0}}, lt_s};
            3'b011:  single_res_s = {{(XLEN-1){1'b0}}, ltu_s};
            3'b100:  single_res_s = bus.x ^ bus.y;
            3'b101:  single_res_s = bus.funct7[5] ? ($signed(bus.x) >>> shamt_s) : (bus.x >> shamt_s);
            3'b110:  single_res_s = bus.x | bus.y;
            3'b111:  single_res_s = bus.x & bus.y;
            default: single_res_s = ZERO;
          endcase
        end
      end
      default: begin
        single_res_s = ZERO;
        single_br_s  = 1'b0;
      end
    endcase
  end

  // ---------------- iterative datapath ----------------
  // Multiply: hi accumulates, lo holds the shifting multiplier, opnd the multiplicand.
  // Divide:   hi is the partial remainder, lo shifts dividend out / quotient in, opnd is the divisor.
  logic [XLEN:0]   add_s, shl_s, trial_s;
  logic [XLEN-1:0] hi_nxt_s, lo_nxt_s;

  assign add_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
  assign shl_s   = {hi_r, lo_r[XLEN-1]};
  assign trial_s = shl_s - {1'b0, opnd_r};

  // One shift-add or restoring-divide step.
  always_comb begin
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (func_r[2]) begin
      if (trial_s[XLEN]) begin
        hi_nxt_s = shl_s[XLEN-1:0];
        lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
      end else begin
        hi_nxt_s = trial_s[XLEN-1:0];
        lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_nxt_s = add_s[XLEN:1];
      lo_nxt_s = {add_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign correction applied to the outcome of the final step.
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, iter_res_s;

  assign prod_s     = {hi_nxt_s, lo_nxt_s};
  assign prod_fix_s = neg_q_r ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
  assign quo_fix_s  = neg_q_r ? (ZERO - lo_nxt_s) : lo_nxt_s;
  assign rem_fix_s  = neg_rem_r ? (ZERO - hi_nxt_s) : hi_nxt_s;

  // Select the signed-corrected slice the M op asked for.
  always_comb begin
    iter_res_s = ZERO;
    case (func_r)
      3'b000:                 iter_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: iter_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         iter_res_s = quo_fix_s;
      3'b110, 3'b111:         iter_res_s = rem_fix_s;
      default:                iter_res_s = ZERO;
    endcase
  end

  // ---------------- control FSM ----------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = iter_op_s ? BUSY : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == {SHW{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (bus.flush || bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready_s  = (state_r == IDLE);
    out_valid_s = (state_r == DONE);
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.result    = result_r;
  assign bus.branch    = branch_r;

  // Operand latching, iteration state and result/branch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {SHW{1'b0}};
      hi_r      <= ZERO;
      lo_r      <= ZERO;
      opnd_r    <= ZERO;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      func_r    <= 3'b000;
      result_r  <= ZERO;
      branch_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            func_r <= bus.funct3;
            if (iter_op_s) begin
              cnt_r     <= SHW'(XLEN - 1);
              hi_r      <= ZERO;
              neg_q_r   <= sx_s ^ sy_s;
              neg_rem_r <= sx_s;
              if (is_div_s) begin
                lo_r   <= mag_x_s;
                opnd_r <= mag_y_s;
              end else begin
                lo_r   <= mag_y_s;
                opnd_r <= mag_x_s;
              end
            end else begin
              result_r <= single_res_s;
              branch_r <= single_br_s;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            cnt_r <= {SHW{1'b0}};
          end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
            if (cnt_r == {SHW{1'b0}}) begin
              result_r <= iter_res_s;
              branch_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r - {{(SHW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
